// File: rtl/dam_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dam_feeder: command, slot-tag and result buffering for the DiffAddMul core |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module dam_feeder #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_i,
  input  logic [7:0] cmd_j,
  input  logic [7:0] cmd_k,
  input  logic       cmd_op,
  output logic [7:0] core_i,
  output logic [7:0] core_j,
  output logic [7:0] core_k,
  output logic       core_op,
  input  logic       core_in_valid,
  input  logic [7:0] core_vo,
  input  logic       core_out_valid,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       err
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [CW:0]   CMD_FULL  = (CW+1)'(CMD_DEPTH);
  localparam logic [TW:0]   TAG_FULL  = (TW+1)'(TAG_DEPTH);
  localparam logic [RW+1:0] RES_LIMIT = (RW+2)'(RES_DEPTH);

  logic [24:0]          cmd_mem_q [CMD_DEPTH];
  logic [CW-1:0]        cmd_wr_q, cmd_rd_q;
  logic [CW:0]          cmd_cnt_q, cmd_cnt_d;
  logic [TAG_DEPTH-1:0] tag_mem_q;
  logic [TW-1:0]        tag_wr_q, tag_rd_q;
  logic [TW:0]          tag_cnt_q, tag_cnt_d;
  logic [7:0]           res_mem_q [RES_DEPTH];
  logic [RW-1:0]        res_wr_q, res_rd_q;
  logic [RW:0]          res_cnt_q, res_cnt_d;
  logic [RW:0]          inflight_q, inflight_d;
  logic [7:0]           res_data_q, res_data_d;
  logic                 err_q, err_d;

  logic          real_ok, tag_full, tag_empty;
  logic          cmd_push, issue_real, tag_push, tag_pop, res_push, res_pop;
  logic [RW+1:0] credit_used;
  logic [24:0]   cmd_head;
  logic [RW-1:0] res_rd_next;

  always_comb begin
    cmd_head    = cmd_mem_q[cmd_rd_q];
    tag_full    = (tag_cnt_q == TAG_FULL);
    tag_empty   = (tag_cnt_q == '0);
    // Results queued plus real slots still inside the core never exceed RES_DEPTH.
    credit_used = {1'b0, res_cnt_q} + {1'b0, inflight_q};
    real_ok     = (cmd_cnt_q != '0) && (credit_used < RES_LIMIT) && !tag_full;

    cmd_push    = cmd_valid && cmd_ready;
    issue_real  = core_in_valid && real_ok;
    tag_push    = core_in_valid && !tag_full;
    tag_pop     = core_out_valid && !tag_empty;
    res_push    = tag_pop && tag_mem_q[tag_rd_q];
    res_pop     = res_valid && res_ready;

    err_d       = err_q | (core_in_valid && tag_full) | (core_out_valid && tag_empty);
    cmd_cnt_d   = cmd_cnt_q + (CW+1)'(cmd_push) - (CW+1)'(issue_real);
    tag_cnt_d   = tag_cnt_q + (TW+1)'(tag_push) - (TW+1)'(tag_pop);
    res_cnt_d   = res_cnt_q + (RW+1)'(res_push) - (RW+1)'(res_pop);
    inflight_d  = inflight_q + (RW+1)'(issue_real) - (RW+1)'(res_push);

    // res_data tracks the head that will be visible after this edge.
    res_rd_next = res_rd_q + 1'b1;
    res_data_d  = res_data_q;
    if (res_pop) begin
      if (res_cnt_q > (RW+1)'(1)) begin
        res_data_d = res_mem_q[res_rd_next];
      end else if (res_push) begin
        res_data_d = core_vo;
      end
    end else if (!res_valid && res_push) begin
      res_data_d = core_vo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      inflight_q <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cmd_push)   cmd_wr_q <= cmd_wr_q + 1'b1;
      if (issue_real) cmd_rd_q <= cmd_rd_q + 1'b1;
      if (tag_push)   tag_wr_q <= tag_wr_q + 1'b1;
      if (tag_pop)    tag_rd_q <= tag_rd_q + 1'b1;
      if (res_push)   res_wr_q <= res_wr_q + 1'b1;
      if (res_pop)    res_rd_q <= res_rd_next;
      cmd_cnt_q  <= cmd_cnt_d;
      tag_cnt_q  <= tag_cnt_d;
      res_cnt_q  <= res_cnt_d;
      inflight_q <= inflight_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  // Storage arrays carry no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {cmd_i, cmd_j, cmd_k, cmd_op};
    if (tag_push) tag_mem_q[tag_wr_q] <= issue_real;
    if (res_push) res_mem_q[res_wr_q] <= core_vo;
  end

  assign cmd_ready = (cmd_cnt_q != CMD_FULL);
  assign core_i    = real_ok ? cmd_head[24:17] : 8'd0;
  assign core_j    = real_ok ? cmd_head[16:9]  : 8'd0;
  assign core_k    = real_ok ? cmd_head[8:1]   : 8'd0;
  assign core_op   = real_ok ? cmd_head[0]     : 1'b1;
  assign res_valid = (res_cnt_q != '0);
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dam_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dam_feeder: directed bench for dam_feeder with a 3-cycle core model     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_dam_feeder;
  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [7:0] cmd_i, cmd_j, cmd_k;
  logic [7:0] core_i, core_j, core_k;
  logic       core_op, core_in_valid, core_out_valid;
  logic [7:0] core_vo;
  logic       res_valid, res_ready, err;
  logic [7:0] res_data;

  dam_feeder #(.CMD_DEPTH(4), .RES_DEPTH(4), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_i(cmd_i), .cmd_j(cmd_j), .cmd_k(cmd_k), .cmd_op(cmd_op),
    .core_i(core_i), .core_j(core_j), .core_k(core_k), .core_op(core_op),
    .core_in_valid(core_in_valid), .core_vo(core_vo), .core_out_valid(core_out_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] i, j, k;
    logic       op;
    int         exp;
  } vec_t;

  int         checks, errors, real_issued;
  logic [7:0] rx[$];
  logic       pv[3];
  logic [7:0] pd[3];
  logic       use_model;

  function automatic logic [7:0] core_fn(input logic [7:0] a, b, c, input logic op);
    logic [7:0]  d;
    logic [15:0] p;
    d = (a > b) ? a - b : b - a;
    p = d * c;
    return op ? d + c : p[7:0];
  endfunction

  function automatic int rx_at(input int n);
    return (rx.size() > n) ? int'(rx[n]) : -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: runs the core model and consumer, then advances one cycle.
  task automatic step();
    if (use_model) begin
      core_out_valid = pv[2];
      core_vo        = pd[2];
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = core_in_valid;
      pd[0] = core_fn(core_i, core_j, core_k, core_op);
    end
    if (core_in_valid && !(core_i == 8'd0 && core_j == 8'd0 && core_k == 8'd0 && core_op))
      real_issued++;
    if (res_valid && res_ready) rx.push_back(res_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; core_in_valid = 1'b0;
    core_out_valid = 1'b0; core_vo = 8'd0; res_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin pv[n] = 1'b0; pd[n] = 8'd0; end
    step(); step();
    rst = 1'b0;
    rx.delete();
    real_issued = 0;
  endtask

  task automatic push_cmd(input logic [7:0] a, b, c, input logic op);
    logic acc;
    int   cyc;
    cmd_i = a; cmd_j = b; cmd_k = c; cmd_op = op; cmd_valid = 1'b1;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 50) begin
      acc = cmd_ready;
      step();
      cyc++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{i: 8'd10,  j: 8'd3,   k: 8'd5,   op: 1'b1, exp: 12};
    vecs[1] = '{i: 8'd2,   j: 8'd9,   k: 8'd3,   op: 1'b0, exp: 21};
    vecs[2] = '{i: 8'd200, j: 8'd50,  k: 8'd100, op: 1'b1, exp: 250};
    vecs[3] = '{i: 8'd0,   j: 8'd255, k: 8'd2,   op: 1'b0, exp: 254};
    vecs[4] = '{i: 8'd7,   j: 8'd7,   k: 8'd9,   op: 1'b0, exp: 0};
    vecs[5] = '{i: 8'd100, j: 8'd20,  k: 8'd200, op: 1'b1, exp: 24};

    checks = 0; errors = 0; real_issued = 0; use_model = 1'b1;
    cmd_i = 8'd0; cmd_j = 8'd0; cmd_k = 8'd0; cmd_op = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data",  int'(res_data),  0);
    check("rst_err",       int'(err),       0);
    check("rst_core_i",    int'(core_i),    0);
    check("rst_core_j",    int'(core_j),    0);
    check("rst_core_k",    int'(core_k),    0);
    check("rst_core_op",   int'(core_op),   1);

    // Single commands among a continuous bubble stream
    core_in_valid = 1'b1; res_ready = 1'b1;
    run(4);
    check("bubbles_dropped", rx.size(), 0);
    for (int v = 0; v < 6; v++) begin
      rx.delete();
      push_cmd(vecs[v].i, vecs[v].j, vecs[v].k, vecs[v].op);
      run(20);
      check($sformatf("vec%0d_count", v), rx.size(), 1);
      check($sformatf("vec%0d_data", v), rx_at(0), vecs[v].exp);
    end
    check("vec_err", int'(err), 0);

    // Backpressure: credit stops real issue at RES_DEPTH
    do_reset();
    core_in_valid = 1'b1; res_ready = 1'b0;
    for (int n = 1; n <= 6; n++) push_cmd(8'(10 * n), 8'(n), 8'(n), 1'b1);
    run(20);
    check("bp_issued4",    real_issued, 4);
    check("bp_res_valid",  int'(res_valid), 1);
    check("bp_head",       int'(res_data), 10);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    run(15);
    check("bp_issued5",    real_issued, 5);
    check("bp_one_popped", rx.size(), 1);
    res_ready = 1'b1;
    run(40);
    check("bp_count", rx.size(), 6);
    for (int n = 0; n < 6; n++) check($sformatf("bp_data%0d", n), rx_at(n), 10 * (n + 1));
    check("bp_issued6", real_issued, 6);
    check("bp_err", int'(err), 0);

    // Command FIFO full with no issue slots
    do_reset();
    core_in_valid = 1'b0; res_ready = 1'b1;
    for (int n = 1; n <= 4; n++) push_cmd(8'(n + 5), 8'd5, 8'd3, 1'b0);
    check("full_cmd_ready", int'(cmd_ready), 0);
    check("full_core_i",    int'(core_i), 6);
    check("full_core_op",   int'(core_op), 0);
    cmd_i = 8'd10; cmd_j = 8'd5; cmd_k = 8'd3; cmd_op = 1'b0; cmd_valid = 1'b1;
    run(3);
    check("full_held", int'(cmd_ready), 0);
    core_in_valid = 1'b1;
    push_cmd(8'd10, 8'd5, 8'd3, 1'b0);
    run(30);
    check("full_count", rx.size(), 5);
    for (int n = 0; n < 5; n++) check($sformatf("full_data%0d", n), rx_at(n), 3 * (n + 1));

    // Same-cycle issue and retire with the tag FIFO one short of full
    do_reset();
    use_model = 1'b0;
    core_in_valid = 1'b1;
    run(7);
    check("sim_tags7", int'(dut.tag_cnt_q), 7);
    core_out_valid = 1'b1; core_vo = 8'h55;
    step();
    core_out_valid = 1'b0;
    check("sim_tags_same", int'(dut.tag_cnt_q), 7);
    check("sim_err",       int'(err), 0);
    check("sim_no_result", int'(res_valid), 0);
    step();
    check("sim_tags_full", int'(dut.tag_cnt_q), 8);
    check("sim_full_noerr", int'(err), 0);
    step();
    check("sim_overflow_err", int'(err), 1);
    check("sim_tags_held",    int'(dut.tag_cnt_q), 8);

    // Stray result with an empty tag FIFO
    do_reset();
    use_model = 1'b0;
    core_in_valid = 1'b0; res_ready = 1'b1;
    core_out_valid = 1'b1; core_vo = 8'h33;
    step();
    core_out_valid = 1'b0;
    check("err_set", int'(err), 1);
    check("err_discard", int'(res_valid), 0);
    run(3);
    check("err_sticky", int'(err), 1);
    use_model = 1'b1;
    core_in_valid = 1'b1;
    push_cmd(8'd10, 8'd3, 8'd5, 1'b1);
    run(20);
    check("err_after_count", rx.size(), 1);
    check("err_after_data",  rx_at(0), 12);
    check("err_still",       int'(err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
